// File: rtl/controlador_elevador_if.sv
// Call-memory port of the elevator sequencer: pending calls in,
// one-cycle clear-write out.
interface controlador_elevador_if;
  logic [3:0] chamadas;
  logic [1:0] endereco;
  logic       escrita;
  logic       dado;

  modport master (
    input  chamadas,
    output endereco,
    output escrita,
    output dado
  );

  modport slave (
    output chamadas,
    input  endereco,
    input  escrita,
    input  dado
  );
endinterface

// File: rtl/controlador_elevador.sv
// Four-floor SCAN elevator sequencer: serves pending calls floor by
// floor, clears each served call and holds the door open at each stop.
module controlador_elevador #(
  parameter int TEMPO_ANDAR = 16,
  parameter int TEMPO_PORTA = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  controlador_elevador_if.master        mem,
  output logic [1:0]                    andar_atual,
  output logic                          subindo,
  output logic                          descendo,
  output logic                          porta_aberta,
  output logic                          ocupado
);

  typedef enum logic [1:0] {
    OCIOSO,
    MOVENDO,
    LIMPAR,
    PORTA
  } estado_t;

  localparam logic [15:0] FIM_ANDAR = 16'(TEMPO_ANDAR - 1);
  localparam logic [15:0] FIM_PORTA = 16'(TEMPO_PORTA - 1);

  estado_t     estado;
  estado_t     prox_estado;
  logic [1:0]  andar;
  logic [1:0]  prox_andar;
  logic        sentido;
  logic        prox_sentido;
  logic [15:0] contador;
  logic [15:0] prox_contador;

  logic [1:0]  andar_seg;
  logic [3:0]  acima_msk;
  logic [3:0]  abaixo_msk;
  logic [3:0]  frente_msk;
  logic        acima;
  logic        abaixo;
  logic        chamada_aqui;
  logic        chamada_seg;
  logic        frente_seg;

  // Masks select calls strictly above / below a floor.
  assign acima_msk  = 4'b1110 << andar;
  assign abaixo_msk = (4'b0001 << andar) - 4'b0001;
  assign acima      = |(mem.chamadas & acima_msk);
  assign abaixo     = |(mem.chamadas & abaixo_msk);

  assign chamada_aqui = mem.chamadas[andar];

  // Floor reached at the end of the current step and what lies beyond it.
  assign andar_seg  = sentido ? andar + 2'd1 : andar - 2'd1;
  assign frente_msk = sentido ? (4'b1110 << andar_seg)
                              : ((4'b0001 << andar_seg) - 4'b0001);
  assign frente_seg  = |(mem.chamadas & frente_msk);
  assign chamada_seg = mem.chamadas[andar_seg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      andar    <= 2'd0;
      sentido  <= 1'b1;
      contador <= 16'd0;
    end else begin
      estado   <= prox_estado;
      andar    <= prox_andar;
      sentido  <= prox_sentido;
      contador <= prox_contador;
    end
  end

  always_comb begin
    prox_estado   = estado;
    prox_andar    = andar;
    prox_sentido  = sentido;
    prox_contador = contador;
    unique case (estado)
      OCIOSO: begin
        prox_contador = 16'd0;
        if (chamada_aqui) begin
          prox_estado = LIMPAR;
        end else if (sentido ? acima : abaixo) begin
          prox_estado = MOVENDO;
        end else if (acima) begin
          prox_sentido = 1'b1;
          prox_estado  = MOVENDO;
        end else if (abaixo) begin
          prox_sentido = 1'b0;
          prox_estado  = MOVENDO;
        end
      end
      MOVENDO: begin
        if (contador == FIM_ANDAR) begin
          prox_andar    = andar_seg;
          prox_contador = 16'd0;
          if (chamada_seg) begin
            prox_estado = LIMPAR;
          end else if (!frente_seg) begin
            prox_estado = OCIOSO;
          end
        end else begin
          prox_contador = contador + 16'd1;
        end
      end
      LIMPAR: begin
        prox_estado   = PORTA;
        prox_contador = 16'd0;
      end
      PORTA: begin
        if (contador == FIM_PORTA) begin
          prox_estado   = OCIOSO;
          prox_contador = 16'd0;
        end else begin
          prox_contador = contador + 16'd1;
        end
      end
      default: begin
        prox_estado   = OCIOSO;
        prox_contador = 16'd0;
      end
    endcase
  end

  // Every output is decoded from registered state only.
  assign andar_atual  = andar;
  assign subindo      = (estado == MOVENDO) && sentido;
  assign descendo     = (estado == MOVENDO) && !sentido;
  assign porta_aberta = (estado == PORTA);
  assign ocupado      = (estado != OCIOSO);
  assign mem.escrita  = (estado == LIMPAR);
  assign mem.endereco = andar;
  assign mem.dado     = 1'b0;

endmodule
